// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions, selects the result source and
// destination register, waits (bounded) for load data, and issues a one-cycle
// register-file write that doubles as the forwarding bundle back to decode.
module wb_stage #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic [15:0]       InstructIn,
    input  logic [DATA_W-1:0] AluResult,
    input  logic [DATA_W-1:0] NextPCIn,
    input  logic              RegWrite,
    input  logic [1:0]        WrMuxSel,
    input  logic [1:0]        WbSrcSel,
    input  logic [DATA_W-1:0] MemRdData,
    input  logic              MemRdValid,
    output logic              WrEn,
    output logic [2:0]        WrAddr,
    output logic [DATA_W-1:0] DataOut,
    output logic              FwdValid,
    output logic [2:0]        FwdAddr,
    output logic [DATA_W-1:0] FwdData,
    output logic              Stall,
    output logic              MemErr
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StWaitMem} stateT;

    stateT stateQ, stateD;

    logic              wrEnQ, wrEnD;
    logic [2:0]        wrAddrQ, wrAddrD;
    logic [DATA_W-1:0] dataOutQ, dataOutD;
    logic [2:0]        pendAddrQ, pendAddrD;
    logic              pendRegWriteQ, pendRegWriteD;
    logic [CntW-1:0]   cntQ, cntD;
    logic              memErrQ, memErrD;

    logic              accept;
    logic              isLoad;
    logic [2:0]        destAddr;
    logic [DATA_W-1:0] srcData;

    assign accept = InValid && InReady;
    assign isLoad = (WbSrcSel == 2'b01);

    // Decode the destination register and non-load result source.
    always_comb begin
        destAddr = 3'd0;
        unique case (WrMuxSel)
            2'b00: destAddr = InstructIn[7:5];
            2'b01: destAddr = InstructIn[4:2];
            2'b10: destAddr = InstructIn[10:8];
            2'b11: destAddr = 3'd7;
            default: destAddr = 3'd0;
        endcase
        srcData = (WbSrcSel == 2'b10) ? NextPCIn : AluResult;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic; memory valid wins over timeout in the same cycle.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle, StWrite: begin
                if (accept) begin
                    stateD = isLoad ? StWaitMem : StWrite;
                end else begin
                    stateD = StIdle;
                end
            end
            StWaitMem: begin
                if (MemRdValid) begin
                    stateD = StWrite;
                end else if (cntQ == CntLast) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Handshake and stall outputs depend on state only.
    always_comb begin
        InReady = (stateQ != StWaitMem);
        Stall   = (stateQ == StWaitMem);
    end

    // Next values of the registered write port, pending load target and timeout.
    always_comb begin
        wrEnD         = 1'b0;
        wrAddrD       = wrAddrQ;
        dataOutD      = dataOutQ;
        pendAddrD     = pendAddrQ;
        pendRegWriteD = pendRegWriteQ;
        cntD          = cntQ;
        memErrD       = memErrQ;
        if (stateQ != StWaitMem) begin
            if (accept) begin
                if (isLoad) begin
                    pendAddrD     = destAddr;
                    pendRegWriteD = RegWrite;
                    cntD          = '0;
                end else if (RegWrite) begin
                    // Address/data only move when a real write goes out.
                    wrEnD    = 1'b1;
                    wrAddrD  = destAddr;
                    dataOutD = srcData;
                end
            end
        end else begin
            if (MemRdValid) begin
                if (pendRegWriteQ) begin
                    wrEnD    = 1'b1;
                    wrAddrD  = pendAddrQ;
                    dataOutD = MemRdData;
                end
            end else if (cntQ == CntLast) begin
                memErrD = 1'b1;
            end else begin
                cntD = cntQ + CntW'(1);
            end
        end
    end

    // Datapath registers; reset discards any pending write or load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrEnQ         <= 1'b0;
            wrAddrQ       <= 3'd0;
            dataOutQ      <= '0;
            pendAddrQ     <= 3'd0;
            pendRegWriteQ <= 1'b0;
            cntQ          <= '0;
            memErrQ       <= 1'b0;
        end else begin
            wrEnQ         <= wrEnD;
            wrAddrQ       <= wrAddrD;
            dataOutQ      <= dataOutD;
            pendAddrQ     <= pendAddrD;
            pendRegWriteQ <= pendRegWriteD;
            cntQ          <= cntD;
            memErrQ       <= memErrD;
        end
    end

    assign WrEn     = wrEnQ;
    assign WrAddr   = wrAddrQ;
    assign DataOut  = dataOutQ;
    assign FwdValid = wrEnQ;
    assign FwdAddr  = wrAddrQ;
    assign FwdData  = dataOutQ;
    assign MemErr   = memErrQ;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a write scoreboard checked on every falling edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [15:0] InstructIn;
    logic [15:0] AluResult;
    logic [15:0] NextPCIn;
    logic        RegWrite;
    logic [1:0]  WrMuxSel;
    logic [1:0]  WbSrcSel;
    logic [15:0] MemRdData;
    logic        MemRdValid;
    logic        WrEn;
    logic [2:0]  WrAddr;
    logic [15:0] DataOut;
    logic        FwdValid;
    logic [2:0]  FwdAddr;
    logic [15:0] FwdData;
    logic        Stall;
    logic        MemErr;

    int errors = 0;
    int checks = 0;
    logic [18:0] expQ[$];

    wb_stage #(.DATA_W(16), .MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .InValid    (InValid),
        .InReady    (InReady),
        .InstructIn (InstructIn),
        .AluResult  (AluResult),
        .NextPCIn   (NextPCIn),
        .RegWrite   (RegWrite),
        .WrMuxSel   (WrMuxSel),
        .WbSrcSel   (WbSrcSel),
        .MemRdData  (MemRdData),
        .MemRdValid (MemRdValid),
        .WrEn       (WrEn),
        .WrAddr     (WrAddr),
        .DataOut    (DataOut),
        .FwdValid   (FwdValid),
        .FwdAddr    (FwdAddr),
        .FwdData    (FwdData),
        .Stall      (Stall),
        .MemErr     (MemErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] modelAddr(input logic [15:0] ins, input logic [1:0] sel);
        case (sel)
            2'b00:   return ins[7:5];
            2'b01:   return ins[4:2];
            2'b10:   return ins[10:8];
            default: return 3'd7;
        endcase
    endfunction

    // Present one instruction; non-load writes are scored immediately.
    task automatic drive(input logic [15:0] ins, input logic [15:0] alu, input logic [15:0] npc,
                         input logic rw, input logic [1:0] wm, input logic [1:0] ws);
        InValid    = 1'b1;
        InstructIn = ins;
        AluResult  = alu;
        NextPCIn   = npc;
        RegWrite   = rw;
        WrMuxSel   = wm;
        WbSrcSel   = ws;
        if (rw && ws != 2'b01) begin
            expQ.push_back({modelAddr(ins, wm), (ws == 2'b10) ? npc : alu});
        end
    endtask

    task automatic idle();
        InValid    = 1'b0;
        MemRdValid = 1'b0;
    endtask

    // Scoreboard: every write or forward must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && (WrEn || FwdValid)) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", 32'(WrEn), 32'd0);
            end else begin
                logic [18:0] e;
                e = expQ.pop_front();
                check("sb_wren", 32'(WrEn), 32'd1);
                check("sb_fwdvalid", 32'(FwdValid), 32'd1);
                check("sb_addr", 32'(WrAddr), 32'(e[18:16]));
                check("sb_fwdaddr", 32'(FwdAddr), 32'(e[18:16]));
                check("sb_data", 32'(DataOut), 32'(e[15:0]));
                check("sb_fwddata", 32'(FwdData), 32'(e[15:0]));
            end
        end
    end

    initial begin
        rst = 1'b1;
        InstructIn = '0; AluResult = '0; NextPCIn = '0; RegWrite = 1'b0;
        WrMuxSel = '0; WbSrcSel = '0; MemRdData = '0;
        idle();
        repeat (2) @(negedge clk);
        check("rst_wren", 32'(WrEn), 32'd0);
        check("rst_wraddr", 32'(WrAddr), 32'd0);
        check("rst_dataout", 32'(DataOut), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_memerr", 32'(MemErr), 32'd0);
        check("rst_inready", 32'(InReady), 32'd1);
        rst = 1'b0;

        // ALU write to r5.
        drive(16'h28A0, 16'h1234, 16'h0000, 1'b1, 2'b00, 2'b00);
        @(negedge clk); idle();
        check("alu_wren", 32'(WrEn), 32'd1);
        check("alu_addr", 32'(WrAddr), 32'd5);
        check("alu_data", 32'(DataOut), 32'h1234);
        check("alu_fwdvalid", 32'(FwdValid), 32'd1);
        @(negedge clk);
        check("alu_wren_drop", 32'(WrEn), 32'd0);

        // Back-to-back ALU writes to r3 then r7.
        drive(16'h0060, 16'h0001, 16'h0000, 1'b1, 2'b00, 2'b00);
        @(negedge clk);
        check("b2b_inready", 32'(InReady), 32'd1);
        check("b2b_addr0", 32'(WrAddr), 32'd3);
        drive(16'h0000, 16'h0002, 16'h0000, 1'b1, 2'b11, 2'b00);
        @(negedge clk); idle();
        check("b2b_wren1", 32'(WrEn), 32'd1);
        check("b2b_addr1", 32'(WrAddr), 32'd7);
        check("b2b_data1", 32'(DataOut), 32'h0002);
        @(negedge clk);
        check("b2b_wren_drop", 32'(WrEn), 32'd0);

        // Load to r2 with data arriving on the third wait cycle.
        drive(16'h0008, 16'h0000, 16'h0000, 1'b1, 2'b01, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            check("ld_stall", 32'(Stall), 32'd1);
            check("ld_inready", 32'(InReady), 32'd0);
            check("ld_wren", 32'(WrEn), 32'd0);
        end
        MemRdValid = 1'b1; MemRdData = 16'hBEEF;
        expQ.push_back({3'd2, 16'hBEEF});
        @(negedge clk); idle();
        check("ld_wren_out", 32'(WrEn), 32'd1);
        check("ld_addr", 32'(WrAddr), 32'd2);
        check("ld_data", 32'(DataOut), 32'hBEEF);
        check("ld_stall_drop", 32'(Stall), 32'd0);

        // Link write of NextPCIn to r7.
        drive(16'h0000, 16'h9999, 16'h0040, 1'b1, 2'b11, 2'b10);
        @(negedge clk); idle();
        check("link_addr", 32'(WrAddr), 32'd7);
        check("link_data", 32'(DataOut), 32'h0040);

        // RegWrite=0 issues nothing and leaves the port values alone.
        drive(16'h00E0, 16'hDEAD, 16'h0000, 1'b0, 2'b00, 2'b00);
        @(negedge clk); idle();
        check("norw_wren", 32'(WrEn), 32'd0);
        check("norw_data_hold", 32'(DataOut), 32'h0040);

        // Load data on exactly the last allowed wait cycle still writes.
        drive(16'h0004, 16'h0000, 16'h0000, 1'b1, 2'b01, 2'b01);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); idle();
            check("edge_stall", 32'(Stall), 32'd1);
        end
        MemRdValid = 1'b1; MemRdData = 16'hA5A5;
        expQ.push_back({3'd1, 16'hA5A5});
        @(negedge clk); idle();
        check("edge_wren", 32'(WrEn), 32'd1);
        check("edge_data", 32'(DataOut), 32'hA5A5);
        check("edge_memerr", 32'(MemErr), 32'd0);

        // Load timeout after 15 wait cycles with no data.
        drive(16'h0010, 16'h0000, 16'h0000, 1'b1, 2'b01, 2'b01);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); idle();
            check("to_stall", 32'(Stall), 32'd1);
            check("to_memerr_early", 32'(MemErr), 32'd0);
        end
        @(negedge clk);
        check("to_memerr", 32'(MemErr), 32'd1);
        check("to_stall_drop", 32'(Stall), 32'd0);
        check("to_wren", 32'(WrEn), 32'd0);
        check("to_inready", 32'(InReady), 32'd1);
        drive(16'h0020, 16'h7777, 16'h0000, 1'b1, 2'b00, 2'b00);
        @(negedge clk); idle();
        check("to_recover_data", 32'(DataOut), 32'h7777);
        check("to_memerr_sticky", 32'(MemErr), 32'd1);

        // Stray memory valid while idle is ignored.
        MemRdValid = 1'b1; MemRdData = 16'h1111;
        repeat (2) @(negedge clk);
        check("stray_wren", 32'(WrEn), 32'd0);
        idle();

        // Reset in the middle of a load discards it.
        drive(16'h0008, 16'h0000, 16'h0000, 1'b1, 2'b01, 2'b01);
        @(negedge clk); idle();
        @(negedge clk);
        check("rml_stall_pre", 32'(Stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rml_stall", 32'(Stall), 32'd0);
        check("rml_wren", 32'(WrEn), 32'd0);
        check("rml_memerr", 32'(MemErr), 32'd0);
        check("rml_inready", 32'(InReady), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        MemRdValid = 1'b1; MemRdData = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rml_no_write", 32'(WrEn), 32'd0);
        end
        idle();
        @(negedge clk);
        check("sb_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 16-bit pipeline. It is the producer end of the register-file write port and of the forwarding path that the decode stage consumes.
- Accepts retiring instructions from the memory stage through a valid/ready handshake.
- Selects the result source and destination register, and waits (with timeout) for load data.
- Drives a one-cycle register write (WrEn/WrAddr/DataOut) plus a forwarding bundle (FwdValid/FwdAddr/FwdData) back to decode.

Parameters:
- DATA_W, 16, datapath width.
- MEM_TIMEOUT, 15, maximum WAIT_MEM cycles before load error (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- InValid  in  1  memory stage presents an instruction.
- InReady  out  1  stage can accept this cycle.
- InstructIn  in  16  retiring instruction word.
- AluResult  in  16  ALU result.
- NextPCIn  in  16  PC+1 of retiring instruction (link value).
- RegWrite  in  1  instruction writes a register.
- WrMuxSel  in  2  destination: 00=InstructIn[7:5], 01=[4:2], 10=[10:8], 11=r7.
- WbSrcSel  in  2  source: 00=AluResult, 01=memory read data, 10=NextPCIn, 11=AluResult.
- MemRdData  in  16  data memory read data.
- MemRdValid  in  1  MemRdData valid this cycle.
- WrEn  out  1  register-file write enable.
- WrAddr  out  3  register-file write address.
- DataOut  out  16  register-file write data.
- FwdValid  out  1  forwarding bundle valid (equals WrEn).
- FwdAddr  out  3  forwarding register (equals WrAddr).
- FwdData  out  16  forwarding data (equals DataOut).
- Stall  out  1  high while waiting on memory.
- MemErr  out  1  sticky load-timeout flag.

Behaviour:
- Reset (async, immediate):
  - State=IDLE.
  - WrEn=0, WrAddr=0, DataOut=0, Stall=0, MemErr=0, timeout counter=0.
  - Any pending write or load is discarded; no write issues after reset deasserts.
- Acceptance:
  - Accept occurs on a rising edge with InValid&InReady.
  - InReady=1 in IDLE and WRITE, 0 in WAIT_MEM.
  - On accept, latch the destination address (per WrMuxSel) and RegWrite.
  - Also latch data when WbSrcSel!=01.
- States:
  - IDLE: WrEn=0. On accept: WbSrcSel==01 -> WAIT_MEM (counter cleared); otherwise -> WRITE.
  - WRITE:
    - Lasts exactly one cycle; WrEn=latched RegWrite; WrAddr/DataOut hold latched values.
    - A simultaneous accept follows the IDLE transition rules, giving back-to-back writes at 1 per cycle for non-loads.
    - With no accept -> IDLE.
  - WAIT_MEM:
    - Stall=1, WrEn=0.
    - MemRdValid=1 -> latch MemRdData -> WRITE. Valid has priority over timeout on the same cycle.
    - Otherwise the counter increments.
    - When counter==MEM_TIMEOUT-1 with no valid: set MemErr, go to IDLE, no write.
- Latency:
  - Non-load: WrEn high in the cycle after the accept edge.
  - Load: WrEn high in the cycle after the edge sampling MemRdValid.
- MemRdValid outside WAIT_MEM is ignored.
- WrAddr/DataOut keep their last values when WrEn=0. Only WrEn qualifies them.
- The decode-stage register file writes on the edge ending the WrEn cycle. The forwarding bundle covers that same-cycle read.
- MemErr is sticky until reset.
- RegWrite=0 instructions still traverse the states, including WAIT_MEM for loads, but WrEn stays 0.
- Counter width is clog2(MEM_TIMEOUT+1) and it never wraps.
- RTL size: registered outputs, 3-state FSM, counter; 120–200 lines.

Test Plan:
- Reset mid-load: enter WAIT_MEM, assert rst -> WrEn/Stall drop immediately; later MemRdValid with 16'hBEEF causes no write.
- ALU write: InstructIn=16'h28A0, WrMuxSel=00, WbSrcSel=00, AluResult=16'h1234, RegWrite=1 -> next cycle WrEn=1, WrAddr=5, DataOut=16'h1234, FwdValid=1; WrEn=0 the cycle after.
- Back-to-back: ALU ops to r3 then r7 (WrMuxSel=11) on consecutive cycles, with AluResult 16'h0001 then 16'h0002 -> WrEn high two consecutive cycles (3/0001, then 7/0002); InReady held 1.
- Load: WbSrcSel=01, WrMuxSel=01, InstructIn[4:2]=3'd2; MemRdValid after 3 cycles with 16'hBEEF:
  - Stall=1 and InReady=0 for 3 cycles.
  - Then WrEn=1, WrAddr=2, DataOut=16'hBEEF.
- Link write: WbSrcSel=10, WrMuxSel=11, NextPCIn=16'h0040 -> WrAddr=7, DataOut=16'h0040.
- Timeout: load with MemRdValid never asserted:
  - MEM_TIMEOUT=15 -> MemErr=1 after 15 WAIT_MEM cycles; return to IDLE; no WrEn; MemErr stays 1.
  - Valid exactly on the 15th cycle -> write occurs, MemErr=0.
